// File: rtl/dwc_pkg.sv
// Shared types and helpers for the dwc output-side blocks.
package dwc_pkg;

    localparam int FCNT_W = 16;

    typedef logic [FCNT_W-1:0] fcnt_t;

    function automatic int cnt_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dwc_frame_cnt.sv
// Wrapping modulo-N counter; wrap is high while the count sits at N-1.
module dwc_frame_cnt #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         wrap
);

    logic [W-1:0] r_q;

    assign wrap = (r_q == W'(N - 1));
    assign q    = r_q;

    // Explicit compare so non-power-of-two N wraps correctly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= wrap ? '0 : r_q + W'(1);
        end
    end

endmodule

// File: rtl/dwc_frame_buf.sv
// Elastic output buffer behind the dwc core with frame marking and fill level.
module dwc_frame_buf
    import dwc_pkg::*;
#(
    parameter int BITS      = 8,
    parameter int DEPTH     = 4,
    parameter int FRAME_LEN = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       irdy,
    input  logic                       ivld,
    input  logic [BITS-1:0]            idat,
    input  logic                       ordy,
    output logic                       ovld,
    output logic [BITS-1:0]            odat,
    output logic                       olast,
    output logic [cnt_bits(DEPTH)-1:0] count
);

    localparam int CW = cnt_bits(DEPTH);
    localparam int PW = $clog2(DEPTH);

    logic [BITS-1:0] r_mem [DEPTH];
    logic [CW-1:0]   r_count;
    logic            r_irdy;
    logic            r_ovld;

    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_cnt_nxt;
    logic [PW-1:0]   w_wptr;
    logic [PW-1:0]   w_rptr;
    logic            w_wwrap;
    logic            w_rwrap;
    fcnt_t           w_fcnt;
    logic            w_flast;

    assign w_push = ivld & r_irdy;
    assign w_pop  = r_ovld & ordy;

    dwc_frame_cnt #(.N(DEPTH), .W(PW)) u_wptr (
        .clk  (clk),
        .rst  (rst),
        .en   (w_push),
        .q    (w_wptr),
        .wrap (w_wwrap)
    );

    dwc_frame_cnt #(.N(DEPTH), .W(PW)) u_rptr (
        .clk  (clk),
        .rst  (rst),
        .en   (w_pop),
        .q    (w_rptr),
        .wrap (w_rwrap)
    );

    dwc_frame_cnt #(.N(FRAME_LEN), .W(FCNT_W)) u_fcnt (
        .clk  (clk),
        .rst  (rst),
        .en   (w_pop),
        .q    (w_fcnt),
        .wrap (w_flast)
    );

    always_comb begin
        w_cnt_nxt = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_count + CW'(1);
            2'b01:   w_cnt_nxt = r_count - CW'(1);
            default: w_cnt_nxt = r_count;
        endcase
    end

    // Ready and valid come from the next count, so neither has a path from ordy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_irdy  <= 1'b0;
            r_ovld  <= 1'b0;
        end else begin
            r_count <= w_cnt_nxt;
            r_irdy  <= (w_cnt_nxt < CW'(DEPTH));
            r_ovld  <= (w_cnt_nxt != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[w_wptr] <= idat;
        end
    end

    assign irdy  = r_irdy;
    assign ovld  = r_ovld;
    assign odat  = r_mem[w_rptr];
    assign olast = w_flast & r_ovld;
    assign count = r_count;

    a_bounds : assert property (@(posedge clk) disable iff (rst)
        (r_count <= CW'(DEPTH)) && !(w_pop && r_count == '0));

endmodule

// File: tb/tb_dwc_frame_buf.sv
// Directed and randomized checks of dwc_frame_buf at DEPTH=4 and DEPTH=3.
module tb_dwc_frame_buf;

    localparam int F = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       a_irdy, a_ivld, a_ordy, a_ovld, a_olast;
    logic [7:0] a_idat, a_odat;
    logic [2:0] a_count;

    logic       b_irdy, b_ivld, b_ordy, b_ovld, b_olast;
    logic [7:0] b_idat, b_odat;
    logic [1:0] b_count;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dwc_frame_buf #(.BITS(8), .DEPTH(4), .FRAME_LEN(F)) u_dut4 (
        .clk   (clk),
        .rst   (rst),
        .irdy  (a_irdy),
        .ivld  (a_ivld),
        .idat  (a_idat),
        .ordy  (a_ordy),
        .ovld  (a_ovld),
        .odat  (a_odat),
        .olast (a_olast),
        .count (a_count)
    );

    dwc_frame_buf #(.BITS(8), .DEPTH(3), .FRAME_LEN(F)) u_dut3 (
        .clk   (clk),
        .rst   (rst),
        .irdy  (b_irdy),
        .ivld  (b_ivld),
        .idat  (b_idat),
        .ordy  (b_ordy),
        .ovld  (b_ovld),
        .odat  (b_odat),
        .olast (b_olast),
        .count (b_count)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [7:0] q[$];
    int         npop;
    int         pushed;
    logic       psh, pp;

    initial begin
        a_ivld = 1'b1; a_idat = 8'h00; a_ordy = 1'b0;
        b_ivld = 1'b1; b_idat = 8'h00; b_ordy = 1'b0;

        // reset held three cycles with ivld high
        repeat (3) @(negedge clk);
        chk("rst_irdy",  32'(a_irdy),  32'd0);
        chk("rst_ovld",  32'(a_ovld),  32'd0);
        chk("rst_count", 32'(a_count), 32'd0);
        chk("rst_olast", 32'(a_olast), 32'd0);
        chk("rst_odat",  32'(a_odat),  32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_irdy",  32'(a_irdy),  32'd1);
        chk("rel_count", 32'(a_count), 32'd0);
        a_ivld = 1'b0;
        b_ivld = 1'b0;

        // pass-through, 1-cycle latency
        a_ordy = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            a_ivld = 1'b1;
            a_idat = 8'(i);
            @(negedge clk);
            chk("pt_ovld",  32'(a_ovld),  32'd1);
            chk("pt_odat",  32'(a_odat),  32'(i));
            chk("pt_olast", 32'(a_olast), 32'(i % 16 == 0));
        end
        a_ivld = 1'b0;
        @(negedge clk);
        chk("pt_empty", 32'(a_count), 32'd0);
        chk("pt_ovld0", 32'(a_ovld),  32'd0);

        // fill with ordy low; fifth word refused
        a_ordy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            a_ivld = 1'b1;
            a_idat = 8'(8'hA0 + k);
            @(negedge clk);
        end
        chk("fill_count", 32'(a_count), 32'd4);
        chk("fill_irdy",  32'(a_irdy),  32'd0);
        chk("fill_odat",  32'(a_odat),  32'hA0);

        // full: pop completes, push refused
        a_idat = 8'hB0;
        a_ordy = 1'b1;
        @(negedge clk);
        chk("full_count", 32'(a_count), 32'd3);
        chk("full_irdy",  32'(a_irdy),  32'd1);
        chk("full_odat",  32'(a_odat),  32'hA1);
        @(negedge clk);
        chk("pp_count", 32'(a_count), 32'd3);
        chk("pp_odat",  32'(a_odat),  32'hA2);
        a_ivld = 1'b0;
        @(negedge clk);
        chk("dr_odat0", 32'(a_odat), 32'hA3);
        @(negedge clk);
        chk("dr_odat1", 32'(a_odat), 32'hB0);
        @(negedge clk);
        chk("dr_empty", 32'(a_count), 32'd0);

        // mid-frame reset: 7 popped, 2 stored
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        a_ordy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_ivld = 1'b1;
            a_idat = 8'(8'h10 + i);
            @(negedge clk);
        end
        a_ordy = 1'b0;
        a_idat = 8'h18;
        @(negedge clk);
        chk("mf_count", 32'(a_count), 32'd2);
        a_ivld = 1'b0;
        rst = 1'b1;
        #1;
        chk("mf_rcount", 32'(a_count), 32'd0);
        chk("mf_rovld",  32'(a_ovld),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        a_ordy = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            a_ivld = 1'b1;
            a_idat = 8'(8'h40 + i);
            @(negedge clk);
            chk("mf_odat",  32'(a_odat),  32'(8'h40 + i));
            chk("mf_olast", 32'(a_olast), 32'(i == 16));
        end
        a_ivld = 1'b0;

        // random stall at DEPTH=3 against a queue model
        npop   = 0;
        pushed = 0;
        for (int cyc = 0; cyc < 60000 && (pushed < 10000 || q.size() != 0);
             cyc++) begin
            chk("rnd_irdy",  32'(b_irdy),  32'(q.size() < 3));
            chk("rnd_ovld",  32'(b_ovld),  32'(q.size() != 0));
            chk("rnd_count", 32'(b_count), 32'(q.size()));
            if (q.size() != 0) chk("rnd_odat", 32'(b_odat), 32'(q[0]));
            chk("rnd_olast", 32'(b_olast),
                32'(q.size() != 0 && npop % F == F - 1));
            if (pushed < 10000) begin
                b_ivld = 1'($urandom_range(0, 1));
                b_ordy = 1'($urandom_range(0, 1));
            end else begin
                b_ivld = 1'b0;
                b_ordy = 1'b1;
            end
            b_idat = 8'($urandom);
            psh = b_ivld && (q.size() < 3);
            pp  = b_ordy && (q.size() != 0);
            @(negedge clk);
            if (pp) begin
                void'(q.pop_front());
                npop++;
            end
            if (psh) begin
                q.push_back(b_idat);
                pushed++;
            end
        end
        chk("rnd_pushed", 32'(pushed), 32'd10000);
        chk("rnd_popped", 32'(npop),   32'd10000);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
